mc_main_control: RTL and testbench
==================================

// Module: mc_main_control
// PURPOSE
//  Multicycle MIPS main control FSM; sits directly upstream of the ALU control decoder.
//  Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
//  Drives datapath enables/muxes and the 3-bit aluop consumed by the ALU control
//  (funct goes straight from IR to ALU control, not through this block).
//  Handles R-type, lw, sw, beq, addi, j; waits on memory via mem_ready.
// PARAMETERS
//  OPCODE_W  6  instruction opcode width
//  ALUOP_W   3  aluop command width (matches ALU control input)
//  STATE_W   4  state register width
// PORTS
//  clk          in   1         single clock, rising edge
//  rst_n        in   1         asynchronous, active-low reset
//  opcode       in   OPCODE_W  IR[31:26], valid from DECODE onward
//  mem_ready    in   1         memory access completes this cycle
//  aluop        out  ALUOP_W   command to ALU control: `ALUOp_CMD_ADD/SUB/RTYPE
//  pc_write     out  1         unconditional PC load
//  pc_write_cond out 1         PC load if ALU zero (branch)
//  i_or_d       out  1         0: mem addr=PC, 1: mem addr=ALUOut
//  mem_read     out  1         memory read request
//  mem_write    out  1         memory write request
//  ir_write     out  1         load IR
//  mem_to_reg   out  1         1: writeback from MDR, 0: from ALUOut
//  reg_dst      out  1         1: rd, 0: rt
//  reg_write    out  1         register file write enable
//  alu_src_a    out  1         0: PC, 1: reg A
//  alu_src_b    out  2         00 B, 01 const 4, 10 sign-ext imm, 11 sext imm<<2
//  pc_source    out  2         00 ALU result, 01 ALUOut, 10 jump target
//  halted       out  1         sticky: illegal opcode decoded
// BEHAVIOUR
//  - Moore FSM; all outputs decoded from registered state only, except ir_write,
//    pc_write, and the FETCH-state PC update, which are qualified by mem_ready.
//  - rst_n=0 (any time, incl. mid-instruction): state<=FETCH immediately.
//    During reset all outputs read 0 except aluop=`ALUOp_CMD_ADD.
//  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, aluop=ADD, pc_source=00.
//    Stay while mem_ready=0. When mem_ready=1: ir_write=1, pc_write=1, then go to DECODE.
//  - DECODE: alu_src_a=0, alu_src_b=11, aluop=ADD (branch target precompute).
//    Next by opcode: 100011/101011->MEM_ADDR; 000000->R_EXEC; 000100->BRANCH;
//    001000->ADDI_EXEC; 000010->JUMP; anything else->HALT.
//  - MEM_ADDR: alu_src_a=1, alu_src_b=10, aluop=ADD; lw->MEM_READ, sw->MEM_WRITE.
//  - MEM_READ: mem_read=1, i_or_d=1; hold until mem_ready, then MEM_WB.
//  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; then FETCH.
//  - MEM_WRITE: mem_write=1, i_or_d=1; hold until mem_ready, then FETCH.
//  - R_EXEC: alu_src_a=1, alu_src_b=00, aluop=RTYPE; then R_WB.
//  - R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; then FETCH.
//  - ADDI_EXEC: alu_src_a=1, alu_src_b=10, aluop=ADD; then ADDI_WB.
//  - ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0; then FETCH.
//  - BRANCH: alu_src_a=1, alu_src_b=00, aluop=SUB, pc_write_cond=1, pc_source=01; then FETCH.
//  - JUMP: pc_write=1, pc_source=10; then FETCH.
//  - HALT: every enable is 0, halted=1; terminal until rst_n.
//  - CPI: R/addi/beq/j = 4/4/3/3; lw=5, sw=4, plus one cycle per mem_ready=0 wait cycle.
//  - mem_read/mem_write are held steady for the whole wait; never both 1 at once.
// CONFIGURATION
//  MC_CTRL_BNE_EN defined: opcode 000101 (bne) in DECODE goes to BRANCH_NE.
//    BRANCH_NE is the same as BRANCH, plus a branch_ne output = 1, so the datapath
//    inverts zero before the PC gate.
//  MC_CTRL_BNE_EN undefined: 000101 -> HALT; no branch_ne port exists.
// STRUCTURE
//  - Shared package/header: state encodings (S_FETCH..S_HALT), opcode constants
//    (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J), and the
//    `ALUOp_CMD_* aluop codes also used by ALU control.
//  - One natural sub-module, mc_opcode_decode: combinational opcode -> one-hot
//    class (rtype/load/store/branch/addi/jump/illegal). Feeds DECODE and MEM_ADDR.
//  - Top: state register, next-state logic, output decode.
// TESTING
//  1 Reset mid-MEM_READ: rst_n low for 1 cycle -> state=FETCH, mem_read=0 during reset, halted=0.
//  2 add (opcode 0), mem_ready=1: FETCH,DECODE,R_EXEC,R_WB (4 cycles);
//    aluop=RTYPE in R_EXEC, reg_write=1 & reg_dst=1 only in R_WB.
//  3 lw with mem_ready low 2 cycles in MEM_READ: 7 cycles total.
//    mem_read=1, i_or_d=1 held for all 3 MEM_READ cycles; mem_to_reg=1 in MEM_WB.
//  4 beq: BRANCH cycle has aluop=SUB, pc_write_cond=1, pc_source=01; next state FETCH.
//  5 opcode 111111: DECODE->HALT, halted=1 and all enables 0 for 20 cycles; rst_n clears it.
//  6 opcode 000101: with MC_CTRL_BNE_EN -> branch_ne=1, pc_write_cond=1;
//    without it -> HALT.

Source files
------------

// File: rtl/mc_main_control_pkg.sv
// Shared constants for the multicycle MIPS main control: aluop codes,
// opcodes, FSM state encoding and the decoded opcode class bundle.
`ifndef MC_ALUOP_CMDS
`define MC_ALUOP_CMDS
`define ALUOp_CMD_ADD   3'b000
`define ALUOp_CMD_SUB   3'b001
`define ALUOp_CMD_RTYPE 3'b010
`endif

package mc_main_control_pkg;

  localparam int OPCODE_W = 6;
  localparam int ALUOP_W  = 3;
  localparam int STATE_W  = 4;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = `ALUOp_CMD_ADD;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = `ALUOp_CMD_SUB;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = `ALUOp_CMD_RTYPE;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_R_EXEC,
    S_R_WB,
    S_ADDI_EXEC,
    S_ADDI_WB,
    S_BRANCH,
    S_BRANCH_NE,
    S_JUMP,
    S_HALT
  } state_t;

  typedef struct packed {
    logic rtype;
    logic load;
    logic store;
    logic branch;
    logic bne;
    logic addi;
    logic jump;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/mc_main_control_if.sv
// Control bus between main control (master) and datapath (slave):
// opcode/mem_ready in, enables, mux selects, aluop and halted out.
// branch_ne exists only when MC_CTRL_BNE_EN is defined.
interface mc_main_control_if;
  import mc_main_control_pkg::*;

  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic [ALUOP_W-1:0]  aluop;
  logic                pc_write;
  logic                pc_write_cond;
  logic                i_or_d;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                mem_to_reg;
  logic                reg_dst;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          pc_source;
  logic                halted;
`ifdef MC_CTRL_BNE_EN
  logic                branch_ne;
`endif

  modport master (
    input  opcode, mem_ready,
    output aluop, pc_write, pc_write_cond,
    output i_or_d, mem_read, mem_write,
    output ir_write, mem_to_reg, reg_dst,
    output reg_write, alu_src_a, alu_src_b,
    output pc_source, halted
`ifdef MC_CTRL_BNE_EN
    , output branch_ne
`endif
  );

  modport slave (
    output opcode, mem_ready,
    input  aluop, pc_write, pc_write_cond,
    input  i_or_d, mem_read, mem_write,
    input  ir_write, mem_to_reg, reg_dst,
    input  reg_write, alu_src_a, alu_src_b,
    input  pc_source, halted
`ifdef MC_CTRL_BNE_EN
    , input branch_ne
`endif
  );

endinterface

// File: rtl/mc_opcode_decode.sv
// Combinational opcode -> one-hot instruction class.
// Ports: opcode in, cls out (exactly one bit set). bne legal only with MC_CTRL_BNE_EN.
module mc_opcode_decode
  import mc_main_control_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_t           cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: cls.rtype  = 1'b1;
      OP_LW:    cls.load   = 1'b1;
      OP_SW:    cls.store  = 1'b1;
      OP_BEQ:   cls.branch = 1'b1;
`ifdef MC_CTRL_BNE_EN
      OP_BNE:   cls.bne    = 1'b1;
`endif
      OP_ADDI:  cls.addi   = 1'b1;
      OP_J:     cls.jump   = 1'b1;
      default:  cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM (FETCH/DECODE/EXEC/MEM/WB).
// Ports: clk, rst_n (async low), bus (master modport). Option: MC_CTRL_BNE_EN.
module mc_main_control
  import mc_main_control_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  mc_main_control_if.master  bus
);

  state_t    state;
  state_t    state_nx;
  op_class_t cls;

  mc_opcode_decode u_dec (
    .opcode (bus.opcode),
    .cls    (cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_FETCH:     if (bus.mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          cls.load,
          cls.store:   state_nx = S_MEM_ADDR;
          cls.rtype:   state_nx = S_R_EXEC;
          cls.branch:  state_nx = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
          cls.bne:     state_nx = S_BRANCH_NE;
`else
          cls.bne:     state_nx = S_HALT;
`endif
          cls.addi:    state_nx = S_ADDI_EXEC;
          cls.jump:    state_nx = S_JUMP;
          cls.illegal: state_nx = S_HALT;
          default:     state_nx = S_HALT;
        endcase
      end
      S_MEM_ADDR:  state_nx = cls.load ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (bus.mem_ready) state_nx = S_MEM_WB;
      S_MEM_WRITE: if (bus.mem_ready) state_nx = S_FETCH;
      S_R_EXEC:    state_nx = S_R_WB;
      S_ADDI_EXEC: state_nx = S_ADDI_WB;
      S_HALT:      state_nx = S_HALT;
      default:     state_nx = S_FETCH;
    endcase
  end

  // Outputs are forced idle while rst_n is low, even though the
  // state register already reads FETCH during reset.
  always_comb begin
    bus.aluop         = ALUOP_ADD;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.pc_source     = 2'b00;
    bus.halted        = 1'b0;
`ifdef MC_CTRL_BNE_EN
    bus.branch_ne     = 1'b0;
`endif
    if (rst_n) begin
      unique case (state)
        S_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        S_DECODE:    bus.alu_src_b = 2'b11;
        S_MEM_ADDR,
        S_ADDI_EXEC: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
        end
        S_MEM_READ: begin
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        S_MEM_WRITE: begin
          bus.mem_write = 1'b1;
          bus.i_or_d    = 1'b1;
        end
        S_R_EXEC: begin
          bus.alu_src_a = 1'b1;
          bus.aluop     = ALUOP_RTYPE;
        end
        S_R_WB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = 1'b1;
        end
        S_ADDI_WB:   bus.reg_write = 1'b1;
        S_BRANCH,
        S_BRANCH_NE: begin
          bus.alu_src_a     = 1'b1;
          bus.aluop         = ALUOP_SUB;
          bus.pc_write_cond = 1'b1;
          bus.pc_source     = 2'b01;
`ifdef MC_CTRL_BNE_EN
          bus.branch_ne     = (state == S_BRANCH_NE);
`endif
        end
        S_JUMP: begin
          bus.pc_write  = 1'b1;
          bus.pc_source = 2'b10;
        end
        S_HALT:      bus.halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_main_control.sv
// Self-checking bench for mc_main_control: CPI table, corner
// sequences and random instruction stream against a phase-plan model.
module tb_mc_main_control;
  import mc_main_control_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mc_main_control_if bus();

  mc_main_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0] aluop;
    logic pc_write;
    logic pc_write_cond;
    logic i_or_d;
    logic mem_read;
    logic mem_write;
    logic ir_write;
    logic mem_to_reg;
    logic reg_dst;
    logic reg_write;
    logic alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic halted;
    logic branch_ne;
  } ctl_t;

  localparam int PH_FETCH = 0;
  localparam int PH_DECODE = 1;
  localparam int PH_ADDR = 2;
  localparam int PH_RD = 3;
  localparam int PH_MWB = 4;
  localparam int PH_WR = 5;
  localparam int PH_REX = 6;
  localparam int PH_RWB = 7;
  localparam int PH_AEX = 8;
  localparam int PH_AWB = 9;
  localparam int PH_BR = 10;
  localparam int PH_BRNE = 11;
  localparam int PH_J = 12;
  localparam int PH_HALT = 13;

  int checks = 0;
  int failures = 0;
  int plan[$];

  function automatic ctl_t expect_ctl(int ph, logic mr, logic rn);
    ctl_t e;
    e = '0;
    e.aluop = `ALUOp_CMD_ADD;
    if (!rn) return e;
    case (ph)
      PH_FETCH: begin
        e.mem_read = 1; e.alu_src_b = 2'b01;
        e.ir_write = mr; e.pc_write = mr;
      end
      PH_DECODE: e.alu_src_b = 2'b11;
      PH_ADDR, PH_AEX: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      PH_RD: begin e.mem_read = 1; e.i_or_d = 1; end
      PH_MWB: begin e.reg_write = 1; e.mem_to_reg = 1; end
      PH_WR: begin e.mem_write = 1; e.i_or_d = 1; end
      PH_REX: begin e.alu_src_a = 1; e.aluop = `ALUOp_CMD_RTYPE; end
      PH_RWB: begin e.reg_write = 1; e.reg_dst = 1; end
      PH_AWB: e.reg_write = 1;
      PH_BR, PH_BRNE: begin
        e.alu_src_a = 1; e.aluop = `ALUOp_CMD_SUB;
        e.pc_write_cond = 1; e.pc_source = 2'b01;
        e.branch_ne = (ph == PH_BRNE);
      end
      PH_J: begin e.pc_write = 1; e.pc_source = 2'b10; end
      PH_HALT: e.halted = 1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic ctl_t get_dut();
    ctl_t d;
    d.aluop = bus.aluop;
    d.pc_write = bus.pc_write;
    d.pc_write_cond = bus.pc_write_cond;
    d.i_or_d = bus.i_or_d;
    d.mem_read = bus.mem_read;
    d.mem_write = bus.mem_write;
    d.ir_write = bus.ir_write;
    d.mem_to_reg = bus.mem_to_reg;
    d.reg_dst = bus.reg_dst;
    d.reg_write = bus.reg_write;
    d.alu_src_a = bus.alu_src_a;
    d.alu_src_b = bus.alu_src_b;
    d.pc_source = bus.pc_source;
    d.halted = bus.halted;
`ifdef MC_CTRL_BNE_EN
    d.branch_ne = bus.branch_ne;
`else
    d.branch_ne = 1'b0;
`endif
    return d;
  endfunction

  task automatic check(string name, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  function automatic void push_route(logic [5:0] op);
    case (op)
      6'b000000: begin plan.push_back(PH_REX); plan.push_back(PH_RWB); end
      6'b100011: begin
        plan.push_back(PH_ADDR); plan.push_back(PH_RD); plan.push_back(PH_MWB);
      end
      6'b101011: begin plan.push_back(PH_ADDR); plan.push_back(PH_WR); end
      6'b000100: plan.push_back(PH_BR);
`ifdef MC_CTRL_BNE_EN
      6'b000101: plan.push_back(PH_BRNE);
`endif
      6'b001000: begin plan.push_back(PH_AEX); plan.push_back(PH_AWB); end
      6'b000010: plan.push_back(PH_J);
      default: plan.push_back(PH_HALT);
    endcase
  endfunction

  function automatic void model_adv();
    int ph;
    if (!rst_n) begin plan = {PH_FETCH}; return; end
    ph = plan[0];
    if (ph == PH_HALT) return;
    if ((ph == PH_FETCH || ph == PH_RD || ph == PH_WR) && !bus.mem_ready) return;
    void'(plan.pop_front());
    if (ph == PH_FETCH) plan.push_back(PH_DECODE);
    else if (ph == PH_DECODE) push_route(bus.opcode);
    if (plan.size() == 0) plan.push_back(PH_FETCH);
  endfunction

  task automatic step();
    ctl_t e;
    @(negedge clk);
    e = expect_ctl(plan[0], bus.mem_ready, rst_n);
    check("ctl", int'(get_dut()), int'(e));
    @(posedge clk);
    model_adv();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic in_fetch();
    return bus.alu_src_b == 2'b01 && bus.mem_read && !bus.i_or_d;
  endfunction

  task automatic run_instr(logic [5:0] op, int waits, output int cyc);
    int wc;
    wc = 0;
    cyc = 0;
    bus.opcode = op;
    do begin
      if (bus.i_or_d && wc < waits) begin
        bus.mem_ready = 1'b0;
        wc++;
      end else begin
        bus.mem_ready = 1'b1;
      end
      step();
      cyc++;
    end while (!in_fetch() && cyc < 40);
  endtask

  typedef struct {
    string name;
    logic [5:0] op;
    int waits;
    int cpi;
  } vec_t;

  vec_t tbl[8];
  logic [5:0] legal_ops[7];

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int guard;
    logic [5:0] op;
    tbl[0] = '{"add", 6'b000000, 0, 4};
    tbl[1] = '{"lw", 6'b100011, 0, 5};
    tbl[2] = '{"lw_w2", 6'b100011, 2, 7};
    tbl[3] = '{"sw", 6'b101011, 0, 4};
    tbl[4] = '{"sw_w3", 6'b101011, 3, 7};
    tbl[5] = '{"beq", 6'b000100, 0, 3};
    tbl[6] = '{"addi", 6'b001000, 0, 4};
    tbl[7] = '{"j", 6'b000010, 0, 3};
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                  6'b000101, 6'b001000, 6'b000010};

    plan = {PH_FETCH};
    bus.opcode = 6'b000000;
    bus.mem_ready = 1'b1;
    do_reset();

    for (int i = 0; i < 8; i++) begin
      run_instr(tbl[i].op, tbl[i].waits, cyc);
      check({"cpi_", tbl[i].name}, cyc, tbl[i].cpi);
    end

    // reset while waiting in MEM_READ
    do_reset();
    bus.opcode = 6'b100011;
    guard = 0;
    while (plan[0] != PH_RD && guard < 20) begin
      step();
      guard++;
    end
    check("reach_mem_read", plan[0], PH_RD);
    bus.mem_ready = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("rst_mem_read", bus.mem_read, 0);
    check("rst_halted", bus.halted, 0);
    step();
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    check("post_rst_fetch", in_fetch(), 1);
    step();

    // illegal opcode halts until reset
    do_reset();
    bus.opcode = 6'b111111;
    step();
    step();
    check("halt_entered", bus.halted, 1);
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = 1'($urandom);
      step();
    end
    check("halt_sticky", bus.halted, 1);
    do_reset();
    check("halt_cleared", bus.halted, 0);

    // bne
    bus.opcode = 6'b000101;
    bus.mem_ready = 1'b1;
    step();
    step();
`ifdef MC_CTRL_BNE_EN
    check("bne_cond", bus.pc_write_cond, 1);
    check("bne_flag", bus.branch_ne, 1);
`else
    check("bne_halt", bus.halted, 1);
`endif
    step();
    do_reset();

    // random instruction stream
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) < 18)
        op = legal_ops[$urandom_range(0, 6)];
      else
        op = 6'($urandom);
      bus.opcode = op;
      guard = 0;
      while (plan[0] == PH_FETCH && guard < 40) begin
        bus.mem_ready = ($urandom_range(0, 3) != 0);
        step();
        guard++;
      end
      while (plan[0] != PH_FETCH && plan[0] != PH_HALT && guard < 80) begin
        bus.mem_ready = ($urandom_range(0, 3) != 0);
        step();
        guard++;
      end
      check("rand_bound", int'(guard < 80), 1);
      if (plan[0] == PH_HALT) begin
        for (int k = 0; k < 3; k++) step();
        do_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
